// File: rtl/frame_cmd_sched.sv
// Sprite command scheduler: queues host command words and broadcasts them in order.
// Ping/pong swap commands are held at the FIFO head until vertical blanking.
//   state   | meaning
//   RUN     | issue or drop one head command per cycle
//   WAIT_VB | swap at head, waiting for vcount to reach blanking
//   HOLD    | swap done this blanking, wait for active video before resuming
module frame_cmd_sched #(
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [9:0] VBLANK_LINE = 10'd480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic        waitrequest,
  output logic [31:0] cmd_out,
  output logic        frame_pp,
  output logic        swap_pending,
  output logic [7:0]  drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] WAIT_VB = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [31:0]   cmd_q, cmd_d;
  logic          frame_pp_q, frame_pp_d;
  logic [7:0]    drop_q, drop_d;

  logic        full, empty, push, pop, issue, drop;
  logic [31:0] head;
  logic [3:0]  head_info;
  logic        unused_hcount;

  assign unused_hcount = ^hcount;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign head      = mem_q[rd_ptr_q];
  assign head_info = head[20:17];
  // A write coinciding with reset must not land in the FIFO.
  assign push      = chipselect & write & ~full & ~reset;

  always_comb begin
    state_d    = state_q;
    frame_pp_d = frame_pp_q;
    pop        = 1'b0;
    issue      = 1'b0;
    drop       = 1'b0;
    case (state_q)
      RUN: begin
        if (!empty) begin
          if (head_info == 4'b1111) begin
            state_d = WAIT_VB;
          end else if (head_info == 4'b0001 && head[13] == frame_pp_q) begin
            pop  = 1'b1;
            drop = 1'b1;
          end else begin
            pop   = 1'b1;
            issue = 1'b1;
          end
        end
      end
      WAIT_VB: begin
        if (vcount >= VBLANK_LINE) begin
          pop        = 1'b1;
          issue      = 1'b1;
          frame_pp_d = head[13];
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (vcount < VBLANK_LINE) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    cmd_d    = issue ? head : 32'h0;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
    drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= RUN;
      cmd_q      <= 32'h0;
      frame_pp_q <= 1'b0;
      drop_q     <= 8'h0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      frame_pp_q <= frame_pp_d;
      drop_q     <= drop_d;
    end
  end

  assign waitrequest  = full;
  assign cmd_out      = cmd_q;
  assign frame_pp     = frame_pp_q;
  assign swap_pending = (state_q == WAIT_VB);
  assign drop_count   = drop_q;

endmodule
